// File: rtl/kernel_line_buffer.sv
// rtl/kernel_line_buffer.sv - raster line buffer emitting KERNEL_SIZE-tall pixel columns
module kernel_line_buffer #(
    parameter int DATA_WIDTH  = 8,
    parameter int IMG_WIDTH   = 854,
    parameter int IMG_HEIGHT  = 480,
    parameter int KERNEL_SIZE = 3,
    parameter int X_WIDTH     = $clog2(IMG_WIDTH),
    parameter int Y_WIDTH     = $clog2(IMG_HEIGHT)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [KERNEL_SIZE*DATA_WIDTH-1:0] out_column,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_border,
    output logic [X_WIDTH-1:0]                out_x,
    output logic [Y_WIDTH-1:0]                out_y,
    output logic                              out_eol,
    output logic                              out_eof
);
    localparam int LINES = KERNEL_SIZE - 1;
    localparam logic [X_WIDTH-1:0] X_LAST       = X_WIDTH'(IMG_WIDTH - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST       = Y_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [Y_WIDTH-1:0] Y_PRIME_LAST = Y_WIDTH'(KERNEL_SIZE - 2);
    localparam logic [X_WIDTH-1:0] X_BORDER     = X_WIDTH'(KERNEL_SIZE - 1);

    typedef enum logic {PRIME, STREAM} state_t;

    state_t                            state;
    state_t                            state_next;
    logic [X_WIDTH-1:0]                col;
    logic [Y_WIDTH-1:0]                row;
    logic [DATA_WIDTH-1:0]             line_mem [LINES][IMG_WIDTH];
    logic [DATA_WIDTH-1:0]             line_rd  [LINES];
    logic [KERNEL_SIZE*DATA_WIDTH-1:0] column;
    logic                              accept;
    logic                              load;
    logic                              col_last;
    logic                              row_last;

    assign in_ready = (state == PRIME) || out_ready || !out_valid;
    assign accept   = in_valid && in_ready;
    assign load     = accept && (state == STREAM);
    assign col_last = (col == X_LAST);
    assign row_last = (row == Y_LAST);

    always_comb begin
        state_next = state;
        if (accept && col_last) begin
            if (state == PRIME && row == Y_PRIME_LAST) begin
                state_next = STREAM;
            end else if (state == STREAM && row_last) begin
                state_next = PRIME;
            end
        end
    end

    // Asynchronous reads give the pre-write contents, so the column sees the old lines.
    always_comb begin
        for (int k = 0; k < LINES; k++) begin
            line_rd[k] = line_mem[k][col];
        end
    end

    always_comb begin
        column = '0;
        column[0 +: DATA_WIDTH] = in_data;
        for (int i = 1; i < KERNEL_SIZE; i++) begin
            column[i*DATA_WIDTH +: DATA_WIDTH] = line_rd[i-1];
        end
    end

    // Lines shift down by one row at the current column on every accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_mem[0][col] <= in_data;
            for (int k = 1; k < LINES; k++) begin
                line_mem[k][col] <= line_rd[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PRIME;
            col   <= '0;
            row   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_column <= '0;
            out_x      <= '0;
            out_y      <= '0;
            out_border <= 1'b0;
            out_eol    <= 1'b0;
            out_eof    <= 1'b0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_column <= column;
            out_x      <= col;
            out_y      <= row;
            out_border <= (col < X_BORDER);
            out_eol    <= col_last;
            out_eof    <= col_last && row_last;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end
endmodule
